// File: rtl/polyphase_dmux.sv
// Registered 1-to-M sample demux: explicit select or round-robin polyphase split.
// Ports: in_data/in_valid/mode/sel/sync in; out_data[M*N], out_valid[M], phase, frame_done, sel_err out.
// Optional build macro DMUX_HOLD_EN: idle channels hold their value instead of clearing to 0.
module polyphase_dmux #(
  parameter int N     = 16,
  parameter int M     = 4,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     in_data,
  input  logic             in_valid,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             sync,
  output logic [M*N-1:0]   out_data,
  output logic [M-1:0]     out_valid,
  output logic [SEL_W-1:0] phase,
  output logic             frame_done,
  output logic             sel_err
);

  localparam logic [SEL_W:0]   MW   = (SEL_W+1)'(M);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(M-1);

  logic [SEL_W-1:0] tgt;
  logic             acc;
  logic             last;
  logic [M-1:0]     hit;
  logic [N-1:0]     chan [M];

  always_comb begin
    tgt = sel;
    unique case (1'b1)
      mode && sync:  tgt = '0;
      mode && !sync: tgt = phase;
      default:       tgt = sel;
    endcase
    acc  = in_valid && ({1'b0, tgt} < MW);
    last = (tgt == LAST);
    for (int k = 0; k < M; k++) begin
      hit[k] = acc && (tgt == SEL_W'(k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= '0;
      out_valid  <= '0;
      frame_done <= 1'b0;
      sel_err    <= 1'b0;
    end else begin
      // wrap at M, not at 2^SEL_W
      if (mode && acc) begin
        phase <= last ? '0 : tgt + SEL_W'(1);
      end else if (sync) begin
        phase <= '0;
      end
      out_valid  <= hit;
      frame_done <= mode && acc && last;
      sel_err    <= !mode && in_valid && !acc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < M; k++) begin
        chan[k] <= '0;
      end
    end else begin
      for (int k = 0; k < M; k++) begin
`ifdef DMUX_HOLD_EN
        if (hit[k]) begin
          chan[k] <= in_data;
        end
`else
        chan[k] <= hit[k] ? in_data : '0;
`endif
      end
    end
  end

  for (genvar k = 0; k < M; k++) begin : g_out
    assign out_data[k*N +: N] = chan[k];
  end

endmodule
